// File: rtl/pwm_bank.sv
// Bank of independent PWM channels with shadowed period/duty registers that commit on wrap.
// Optional output polarity control is enabled by defining PWM_BANK_POLARITY_EN.
module pwm_bank #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [CNT_W-1:0]  cfg_duty_i,
`ifdef PWM_BANK_POLARITY_EN
  input  logic              cfg_pol_i,
`endif
  output logic [N_CH-1:0]   pwm_o,
  output logic [N_CH-1:0]   period_evt_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q      [N_CH];
  state_t           state_d      [N_CH];
  logic [CNT_W-1:0] cnt_q        [N_CH];
  logic [CNT_W-1:0] cnt_d        [N_CH];
  logic [CNT_W-1:0] act_period_q [N_CH];
  logic [CNT_W-1:0] act_period_d [N_CH];
  logic [CNT_W-1:0] act_duty_q   [N_CH];
  logic [CNT_W-1:0] act_duty_d   [N_CH];
  logic [CNT_W-1:0] sh_period_q  [N_CH];
  logic [CNT_W-1:0] sh_period_d  [N_CH];
  logic [CNT_W-1:0] sh_duty_q    [N_CH];
  logic [CNT_W-1:0] sh_duty_d    [N_CH];
`ifdef PWM_BANK_POLARITY_EN
  logic             act_pol_q    [N_CH];
  logic             act_pol_d    [N_CH];
  logic             sh_pol_q     [N_CH];
  logic             sh_pol_d     [N_CH];
`endif
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic [N_CH-1:0]  evt_q, evt_d;
  logic             accept;

  assign cfg_ready_o  = !rst_i;
  assign accept       = cfg_valid_i && cfg_ready_o;
  assign pwm_o        = pwm_q;
  assign period_evt_o = evt_q;

  always_comb begin
    logic             hit;
    logic             commit;
    logic             running;
    logic             raw;
    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] eff_duty;
`ifdef PWM_BANK_POLARITY_EN
    logic             eff_pol;
    eff_pol = 1'b0;
`endif
    hit        = 1'b0;
    commit     = 1'b0;
    running    = 1'b0;
    raw        = 1'b0;
    eff_period = '0;
    eff_duty   = '0;
    pwm_d      = '0;
    evt_d      = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      state_d[c]      = state_q[c];
      cnt_d[c]        = cnt_q[c];
      act_period_d[c] = act_period_q[c];
      act_duty_d[c]   = act_duty_q[c];

      // A write landing in the same cycle as a commit is forwarded straight into the active set.
      hit             = accept && (32'(cfg_ch_i) == c);
      eff_period      = hit ? cfg_period_i : sh_period_q[c];
      eff_duty        = hit ? cfg_duty_i   : sh_duty_q[c];
      sh_period_d[c]  = eff_period;
      sh_duty_d[c]    = eff_duty;
`ifdef PWM_BANK_POLARITY_EN
      eff_pol         = hit ? cfg_pol_i : sh_pol_q[c];
      sh_pol_d[c]     = eff_pol;
      act_pol_d[c]    = act_pol_q[c];
`endif
      commit          = 1'b0;

      case (state_q[c])
        IDLE: begin
          cnt_d[c] = '0;
          if (en_i[c]) begin
            state_d[c] = RUN;
            commit     = 1'b1;
          end
        end
        RUN: begin
          if (!en_i[c]) begin
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
          end else if (act_period_q[c] == '0) begin
            // Zero period parks the counter but keeps committing so a later write restarts it.
            cnt_d[c] = '0;
            commit   = 1'b1;
          end else if (cnt_q[c] == act_period_q[c] - 1'b1) begin
            cnt_d[c] = '0;
            commit   = 1'b1;
            evt_d[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
        default: state_d[c] = IDLE;
      endcase

      if (commit) begin
        act_period_d[c] = eff_period;
        act_duty_d[c]   = eff_duty;
`ifdef PWM_BANK_POLARITY_EN
        act_pol_d[c]    = eff_pol;
`endif
      end

      running = (state_q[c] == RUN) && en_i[c];
      raw     = running && (act_period_q[c] != '0) && (cnt_q[c] < act_duty_q[c]);
`ifdef PWM_BANK_POLARITY_EN
      pwm_d[c] = running ? (raw ^ act_pol_q[c]) : act_pol_d[c];
`else
      pwm_d[c] = raw;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        state_q[c]      <= IDLE;
        cnt_q[c]        <= '0;
        act_period_q[c] <= '0;
        act_duty_q[c]   <= '0;
        sh_period_q[c]  <= '0;
        sh_duty_q[c]    <= '0;
`ifdef PWM_BANK_POLARITY_EN
        act_pol_q[c]    <= 1'b0;
        sh_pol_q[c]     <= 1'b0;
`endif
      end
      pwm_q <= '0;
      evt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
`ifdef PWM_BANK_POLARITY_EN
      act_pol_q    <= act_pol_d;
      sh_pol_q     <= sh_pol_d;
`endif
      pwm_q <= pwm_d;
      evt_q <= evt_d;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: directed stimulus pushes per-cycle expected bits,
// a monitor pops and compares them one time unit after each rising edge.
module tb_pwm_bank;
  localparam int unsigned N_CH  = 6;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 3;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
`ifdef PWM_BANK_POLARITY_EN
  logic             cfg_pol;
`endif
  logic [N_CH-1:0]  pwm;
  logic [N_CH-1:0]  evt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int   cyc;
    int   ch;
    int   kind;  // 0 pwm, 1 period event, 2 cfg ready
    logic val;
  } exp_t;

  exp_t sb[$];

  pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_period_i (cfg_period),
    .cfg_duty_i   (cfg_duty),
`ifdef PWM_BANK_POLARITY_EN
    .cfg_pol_i    (cfg_pol),
`endif
    .pwm_o        (pwm),
    .period_evt_o (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int ch, int kind, logic v);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endfunction

  function automatic void push_pe(int c, int ch, logic [1:0] pe);
    push(c, ch, 0, pe[1]);
    push(c, ch, 1, pe[0]);
  endfunction

  // {pwm, evt} at offset j (j=0 is the first possible high cycle) of a run with period p, duty d
  function automatic logic [1:0] run_pe(int j, int p, int d);
    logic [1:0] r;
    r[1] = ((j % p) < d)     ? 1'b1 : 1'b0;
    r[0] = ((j % p) == p - 1) ? 1'b1 : 1'b0;
    return r;
  endfunction

  // Hand-derived expectations for the main run (en rises at cycle 12, reset at cycle 50)
  function automatic logic [1:0] main_pe(int ch, int c);
    if (c == 13) return 2'b00;
    case (ch)
      0: return run_pe(c - 14, 4, 1);
      1: begin
        if (c <= 26) return run_pe(c - 14, 6, 3);
        if (c <= 30) return 2'b00;
        return run_pe(c - 31, 6, 3);
      end
      2: begin
        if (c <= 33) return run_pe(c - 14, 10, 5);
        if (c <= 45) return run_pe(c - 34, 4, 2);
        return run_pe(c - 46, 5, 1);
      end
      3: begin
        if (c <= 38) return {1'b0, ((c - 14) % 5 == 4) ? 1'b1 : 1'b0};
        return {1'b1, ((c - 39) % 4 == 3) ? 1'b1 : 1'b0};
      end
      4: return {1'b1, ((c - 14) % 5 == 4) ? 1'b1 : 1'b0};
      default: return (c >= 42) ? 2'b11 : 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] post_pe(int ch, int c);
    if (ch == 0 && c >= 60) return run_pe(c - 60, 2, 1);
    return 2'b00;
  endfunction

  task automatic wait_cyc(int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic write_at(int k, int ch, int p, int d);
    wait_cyc(k);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
    wait_cyc(k + 1);
    cfg_valid  = 1'b0;
  endtask

  // Monitor: compares every expectation scheduled for the cycle just registered
  initial begin
    logic got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            0:       begin got = pwm[sb[i].ch]; nm = "pwm";   end
            1:       begin got = evt[sb[i].ch]; nm = "evt";   end
            default: begin got = cfg_ready;     nm = "ready"; end
          endcase
          checks++;
          if (got !== sb[i].val) begin
            failures++;
            $display("FAIL %s ch%0d cycle%0d got=%b exp=%b", nm, sb[i].ch, cyc, got, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  // Direct spot checks of bus-wide outputs at key cycles
  initial begin
    do begin @(posedge clk); #1; end while (cyc != 2);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL spot ready cycle2 got=%b", cfg_ready);
    end
    checks++;
    if ((pwm | evt) !== '0) begin
      failures++;
      $display("FAIL spot outputs cycle2 pwm=%b evt=%b", pwm, evt);
    end
    do begin @(posedge clk); #1; end while (cyc != 5);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL spot ready cycle5 got=%b", cfg_ready);
    end
    do begin @(posedge clk); #1; end while (cyc != 14);
    checks++;
    if (pwm !== 6'b010111) begin
      failures++;
      $display("FAIL spot pwm cycle14 got=%b exp=010111", pwm);
    end
    checks++;
    if (evt !== '0) begin
      failures++;
      $display("FAIL spot evt cycle14 got=%b", evt);
    end
    do begin @(posedge clk); #1; end while (cyc != 51);
    checks++;
    if (pwm !== '0) begin
      failures++;
      $display("FAIL spot pwm cycle51 got=%b", pwm);
    end
    checks++;
    if (evt !== '0) begin
      failures++;
      $display("FAIL spot evt cycle51 got=%b", evt);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL spot ready cycle51 got=%b", cfg_ready);
    end
  end

  initial begin
    rst        = 1'b1;
    en         = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_duty   = '0;
`ifdef PWM_BANK_POLARITY_EN
    cfg_pol    = 1'b0;
`endif
    for (int ch = 0; ch < int'(N_CH); ch++) push_pe(2, ch, 2'b00);
    push(2, -1, 2, 1'b0);
    push(5, -1, 2, 1'b1);

    wait_cyc(3);
    rst = 1'b0;

    write_at(5,  0, 4, 1);
    write_at(6,  1, 6, 3);
    write_at(7,  2, 10, 5);
    write_at(8,  3, 5, 0);
    write_at(9,  4, 5, 5);
    write_at(10, 5, 0, 3);

    wait_cyc(12);
    for (int c = 13; c <= 50; c++)
      for (int ch = 0; ch < int'(N_CH); ch++) push_pe(c, ch, main_pe(ch, c));
    en = '1;

    write_at(25, 2, 4, 2);
    en[1] = 1'b0;
    wait_cyc(29);
    en[1] = 1'b1;
    write_at(35, 3, 4, 7);
    write_at(40, 5, 1, 1);
    write_at(44, 2, 5, 1);

    wait_cyc(50);
    for (int c = 51; c <= 66; c++)
      for (int ch = 0; ch < int'(N_CH); ch++) push_pe(c, ch, post_pe(ch, c));
    push(51, -1, 2, 1'b0);
    push(56, -1, 2, 1'b1);
    rst = 1'b1;

    write_at(51, 0, 2, 1);
    rst = 1'b0;
    write_at(56, 6, 3, 1);
    write_at(58, 0, 2, 1);

    wait_cyc(68);
    while (sb.size() > 0) begin
      failures++;
      $display("FAIL unchecked kind%0d ch%0d cycle%0d exp=%b", sb[0].kind, sb[0].ch, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of PWM channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, counter/period/duty width (2..32).
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port en_i  input  N_CH  per-channel run enable, level-sensitive.
REQ-006 SHALL have port cfg_valid_i  input  1  config write request.
REQ-007 SHALL have port cfg_ready_o  output  1  config write acceptance.
REQ-008 SHALL have port cfg_ch_i  input  $clog2(N_CH) (min 1)  target channel index.
REQ-009 SHALL have port cfg_period_i  input  CNT_W  period in clk_i cycles.
REQ-010 SHALL have port cfg_duty_i  input  CNT_W  high time in clk_i cycles.
REQ-011 SHALL have port pwm_o  output  N_CH  registered PWM outputs to pads.
REQ-012 SHALL have port period_evt_o  output  N_CH  one-cycle pulse per completed period.

Function
REQ-013 SHALL accept a config write when cfg_valid_i && cfg_ready_o; cfg_ready_o SHALL be 1 in every cycle except while rst_i is high.
REQ-014 SHALL store accepted period/duty in the target channel's shadow registers only; writes with cfg_ch_i >= N_CH SHALL be accepted and discarded.
REQ-015 Each channel SHALL have states IDLE and RUN; IDLE when en_i[c]=0, with counter held at 0.
REQ-016 IDLE->RUN when en_i[c]=1: active period/duty loaded from shadow, counter=0.
REQ-017 RUN->IDLE on any cycle en_i[c]=0; counter cleared, pwm_o[c] low the following cycle.
REQ-018 In RUN: if counter == active_period-1, counter->0, shadow committed to active, period_evt_o[c] pulses high for exactly one cycle on the next cycle; else counter increments by 1.
REQ-019 pwm_o[c] SHALL be registered: high in cycle t+1 iff channel in RUN in cycle t and counter_t < active_duty_t; first high cycle is 2 cycles after en_i[c] rises.
REQ-020 duty=0 -> pwm_o[c] constantly low; duty >= period -> constantly high while RUN.
REQ-021 period=0 active -> counter held 0, pwm_o[c] low, no period_evt_o, shadow committed every cycle so a later non-zero write starts the channel.
REQ-022 period=1 -> wrap and period_evt_o pulse every cycle.
REQ-023 A write accepted in the same cycle as a commit (wrap or IDLE->RUN) on that channel SHALL bypass: the new values become active at that commit.
REQ-024 Channels SHALL operate independently; simultaneous wraps on several channels SHALL all commit.

Reset
REQ-025 rst_i high SHALL clear pwm_o, period_evt_o, cfg_ready_o, counters, states (IDLE), shadow and active registers to 0, effective the cycle after rst_i is sampled, including mid-period.
REQ-026 Writes presented while rst_i high SHALL be ignored.

Configuration
REQ-027 Macro PWM_BANK_POLARITY_EN: when defined, SHALL add input cfg_pol_i (1 bit), shadowed/committed with period/duty; active pol=1 inverts pwm_o[c] in RUN, and in IDLE/reset pwm_o[c] SHALL equal the committed polarity (reset value 0).
REQ-028 When PWM_BANK_POLARITY_EN is undefined, cfg_pol_i SHALL not exist and outputs are non-inverted.

Verification
REQ-029 ch0 period=4 duty=1, en_i[0] rises at cycle 0 -> pwm_o[0] = 1,0,0,0 repeating from cycle 2; period_evt_o[0] pulses at cycles 5, 9, 13.
REQ-030 ch2 running period=10 duty=5; write period=4 duty=2 mid-period -> old waveform completes, new 1,1,0,0 pattern starts exactly at next wrap; write coincident with wrap takes effect at that wrap.
REQ-031 duty=0, duty=period, duty=period+3, period=0, period=1 each on separate channels -> constant low, constant high, constant high, low/no events, event every cycle.
REQ-032 en_i[1] dropped mid-period then re-raised -> pwm_o[1] low next cycle, counter restarts at 0, first high 2 cycles after re-raise; rst_i asserted mid-run -> all outputs 0 next cycle, cfg_ready_o 0 during reset.
REQ-033 cfg_ch_i=N_CH (N_CH non-power-of-2, e.g. 6) -> handshake completes, no channel changes.
REQ-034 With PWM_BANK_POLARITY_EN, pol=1 period=4 duty=1 -> pwm_o = 0,1,1,1; IDLE level 1 after commit.
